csr_file: RTL

- Machine-mode CSR storage for the pipelined core.
- Receiver of the writeback stage's CSR write port. Commits CSR writes handed over under the valid/ready handshake.
- Serves combinational CSR reads to decode/execute.
- Applies trap side effects for ecall/mret and supplies the redirect PCs (mtvec, mepc) to fetch.

---
 rtl/csr_file.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: registered CSR writes under a valid/ready handshake, combinational reads,
// and the ecall/mret side effects. Define CSR_MCYCLE_EN to implement the mcycle/mcycleh counter.
module csr_file #(
   parameter logic [31:0] MVENDORID = 32'h0000_0000,
   parameter logic [31:0] MARCHID   = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_pre_i,
   output logic        ready_pre_o,
   input  logic        csr_wena_i,
   input  logic [31:0] csr_waddr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic [31:0] raddr_i,
   output logic [31:0] rdata_o,
   output logic        rerr_o,
   input  logic        ecall_i,
   input  logic [31:0] ecall_pc_i,
   input  logic        mret_i,
   output logic [31:0] trap_pc_o,
   output logic [31:0] mret_pc_o
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
`ifdef CSR_MCYCLE_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
`endif

   logic        mie;
   logic        mpie;
   logic [31:2] mtvec;
   logic [31:2] mepc;
   logic [31:0] mcause;
   logic [31:0] mstatus_value;

   logic        fire;
   logic        wr_en;
   logic [11:0] waddr;
   logic        wr_mstatus;
   logic        wr_mtvec;
   logic        wr_mepc;
   logic        wr_mcause;

   // Trap events own the register file for their commit cycle, so the beat is stalled.
   assign ready_pre_o = reset & ~ecall_i & ~mret_i;
   assign fire        = valid_pre_i & ready_pre_o;
   assign wr_en       = fire & csr_wena_i & (csr_waddr_i[31:12] == 20'h0_0000);
   assign waddr       = csr_waddr_i[11:0];

   assign wr_mstatus = wr_en & (waddr == ADDR_MSTATUS);
   assign wr_mtvec   = wr_en & (waddr == ADDR_MTVEC);
   assign wr_mepc    = wr_en & (waddr == ADDR_MEPC);
   assign wr_mcause  = wr_en & (waddr == ADDR_MCAUSE);

   // MPP is hardwired to machine mode.
   assign mstatus_value = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

   assign trap_pc_o = {mtvec, 2'b00};
   assign mret_pc_o = {mepc, 2'b00};

   always_ff @(posedge clock) begin
      if (!reset) begin
         mie    <= 1'b0;
         mpie   <= 1'b0;
         mtvec  <= '0;
         mepc   <= '0;
         mcause <= '0;
      end else if (ecall_i) begin
         mepc   <= ecall_pc_i[31:2];
         mcause <= 32'd11;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_i) begin
         mie    <= mpie;
         mpie   <= 1'b1;
      end else begin
         if (wr_mstatus) begin
            mie  <= csr_wdata_i[3];
            mpie <= csr_wdata_i[7];
         end
         if (wr_mtvec) begin
            mtvec <= csr_wdata_i[31:2];
         end
         if (wr_mepc) begin
            mepc <= csr_wdata_i[31:2];
         end
         if (wr_mcause) begin
            mcause <= csr_wdata_i;
         end
      end
   end

`ifdef CSR_MCYCLE_EN
   logic [31:0] mcycle;
   logic [31:0] mcycleh;
   logic        wr_mcycle;
   logic        wr_mcycleh;

   assign wr_mcycle  = wr_en & (waddr == ADDR_MCYCLE);
   assign wr_mcycleh = wr_en & (waddr == ADDR_MCYCLEH);

   // A write to either half freezes the whole counter for that cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mcycle  <= '0;
         mcycleh <= '0;
      end else if (wr_mcycle) begin
         mcycle <= csr_wdata_i;
      end else if (wr_mcycleh) begin
         mcycleh <= csr_wdata_i;
      end else begin
         {mcycleh, mcycle} <= {mcycleh, mcycle} + 64'd1;
      end
   end
`endif

   always_comb begin
      rdata_o = 32'h0;
      rerr_o  = 1'b0;
      if (raddr_i[31:12] != 20'h0_0000) begin
         rerr_o = 1'b1;
      end else begin
         case (raddr_i[11:0])
            ADDR_MSTATUS:   rdata_o = mstatus_value;
            ADDR_MTVEC:     rdata_o = {mtvec, 2'b00};
            ADDR_MEPC:      rdata_o = {mepc, 2'b00};
            ADDR_MCAUSE:    rdata_o = mcause;
            ADDR_MVENDORID: rdata_o = MVENDORID;
            ADDR_MARCHID:   rdata_o = MARCHID;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:    rdata_o = mcycle;
            ADDR_MCYCLEH:   rdata_o = mcycleh;
`endif
            default:        rerr_o  = 1'b1;
         endcase
      end
   end

   // The low PC bits are always discarded since mepc is word aligned.
   logic unused_ecall_pc;
   assign unused_ecall_pc = ^ecall_pc_i[1:0];

endmodule
